// File: rtl/sid_audio_pkg.sv
// Shared SID audio-path definitions: the sample type used between the filter,
// decimator and I2S stages, plus default decimation and FIFO sizing.
package sid_audio_pkg;

  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned DECIM_LOG2_DEF = 4;
  localparam int unsigned FIFO_LOG2_DEF  = 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage : sid_audio_pkg

// File: rtl/sample_fifo.sv
// sample_fifo: small synchronous FIFO of audio samples with a registered head.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push         write push_data (accepted when not full, or full with pop)
//   push_data    sample to store
//   pop          advance head (ignored when empty)
//   head         current head; holds the last-popped value while empty
//   valid        FIFO not empty
//   level        occupancy, 0..2^FIFO_LOG2
//   full_c       combinational full flag
//   empty_c      combinational empty flag
module sample_fifo
  import sid_audio_pkg::*;
#(
  parameter int unsigned FIFO_LOG2 = FIFO_LOG2_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  sample_t            push_data,
  input  logic               pop,
  output sample_t            head,
  output logic               valid,
  output logic [FIFO_LOG2:0] level,
  output logic               full_c,
  output logic               empty_c
);

  localparam int unsigned PW    = FIFO_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << FIFO_LOG2;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  sample_t       mem_q [DEPTH];
  sample_t       mem_d [DEPTH];
  sample_t       head_q, head_d;
  logic          valid_q, valid_d;
  logic          wr_en_c, rd_en_c;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign full_c  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);

  // A full FIFO still accepts a write when the head is popped on the same edge.
  assign wr_en_c = push & (~full_c | pop);
  assign rd_en_c = pop & ~empty_c;

  // Next-state: storage, pointers, occupancy and the registered head.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (wr_en_c) begin
      mem_d[wr_ptr_q[FIFO_LOG2-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_en_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    level_d = wr_ptr_d - rd_ptr_d;
    valid_d = (level_d != '0);
    // Reading mem_d forwards a write into an empty FIFO straight to the head;
    // when the FIFO drains the head keeps the value just popped.
    if (valid_d) begin
      head_d = mem_d[rd_ptr_d[FIFO_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign level = level_q;

endmodule : sample_fifo

// File: rtl/sample_decimator.sv
// sample_decimator: averages 2^DECIM_LOG2 SID samples into one output sample,
// queues results in a small FIFO for the I2S encoder and keeps saturating
// underrun/overrun statistics.
// Optional build macro: DECIM_ROUND_EN -- round-half-up before the shift and
// saturate to 16 bits; without it the average is truncated (floor).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   in_en          one-cycle sample strobe
//   in_sample      signed input sample, valid with in_en
//   out_take       one-cycle pop request
//   out_sample     FIFO head (last-popped value while empty)
//   out_valid      FIFO not empty
//   level          FIFO occupancy
//   clr_stats      synchronous clear of both counters
//   underrun_cnt   saturating count of pops while empty
//   overrun_cnt    saturating count of dropped pushes
module sample_decimator
  import sid_audio_pkg::*;
#(
  parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DEF,
  parameter int unsigned FIFO_LOG2  = FIFO_LOG2_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_en,
  input  sample_t            in_sample,
  input  logic               out_take,
  output sample_t            out_sample,
  output logic               out_valid,
  output logic [FIFO_LOG2:0] level,
  input  logic               clr_stats,
  output logic [7:0]         underrun_cnt,
  output logic [7:0]         overrun_cnt
);

  localparam int unsigned ACC_W = SAMPLE_W + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] PHASE_LAST = '1;

  logic signed [ACC_W-1:0] accum_q, accum_d;
  logic signed [ACC_W-1:0] sum_c;
  logic [DECIM_LOG2-1:0]   phase_q, phase_d;
  sample_t                 result_c;
  logic                    push_c;
  logic                    fifo_full_c, fifo_empty_c;
  logic                    underrun_inc_c, overrun_inc_c;
  logic [7:0]              underrun_cnt_q, underrun_cnt_d;
  logic [7:0]              overrun_cnt_q, overrun_cnt_d;

  // Running sum including the current sample; a full block of 2^DECIM_LOG2
  // 16-bit samples always fits in ACC_W bits.
  assign sum_c = accum_q + ACC_W'(in_sample);

`ifdef DECIM_ROUND_EN
  localparam int unsigned RND_W = ACC_W + 1;
  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1 << (DECIM_LOG2 - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'(32767);
  localparam logic signed [RND_W-1:0] SAT_MIN  = RND_W'(-32768);

  logic signed [RND_W-1:0] rnd_sum_c, rnd_shift_c;

  // Round half up, then clamp to the 16-bit sample range.
  always_comb begin
    rnd_sum_c   = RND_W'(sum_c) + RND_HALF;
    rnd_shift_c = rnd_sum_c >>> DECIM_LOG2;
    result_c    = SAMPLE_W'(rnd_shift_c);
    if (rnd_shift_c > SAT_MAX) begin
      result_c = SAMPLE_W'(SAT_MAX);
    end else if (rnd_shift_c < SAT_MIN) begin
      result_c = SAMPLE_W'(SAT_MIN);
    end
  end
`else
  // Arithmetic shift floors the average; the result always fits 16 bits.
  assign result_c = SAMPLE_W'(sum_c >>> DECIM_LOG2);
`endif

  // Accumulate on each strobe; the last strobe of a block pushes and restarts.
  always_comb begin
    accum_d = accum_q;
    phase_d = phase_q;
    push_c  = 1'b0;
    if (in_en) begin
      if (phase_q == PHASE_LAST) begin
        accum_d = '0;
        phase_d = '0;
        push_c  = 1'b1;
      end else begin
        accum_d = sum_c;
        phase_d = phase_q + DECIM_LOG2'(1);
      end
    end
  end

  // A full FIFO with a same-cycle take accepts the push, so only count a drop
  // when no take frees a slot.
  assign underrun_inc_c = out_take & fifo_empty_c;
  assign overrun_inc_c  = push_c & fifo_full_c & ~out_take;

  // Saturating statistics; clear wins over a same-cycle increment.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    overrun_cnt_d  = overrun_cnt_q;
    if (clr_stats) begin
      underrun_cnt_d = '0;
      overrun_cnt_d  = '0;
    end else begin
      if (underrun_inc_c && (underrun_cnt_q != 8'hFF)) begin
        underrun_cnt_d = underrun_cnt_q + 8'd1;
      end
      if (overrun_inc_c && (overrun_cnt_q != 8'hFF)) begin
        overrun_cnt_d = overrun_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum_q        <= '0;
      phase_q        <= '0;
      underrun_cnt_q <= '0;
      overrun_cnt_q  <= '0;
    end else begin
      accum_q        <= accum_d;
      phase_q        <= phase_d;
      underrun_cnt_q <= underrun_cnt_d;
      overrun_cnt_q  <= overrun_cnt_d;
    end
  end

  sample_fifo #(
    .FIFO_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (result_c),
    .pop       (out_take),
    .head      (out_sample),
    .valid     (out_valid),
    .level     (level),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  assign underrun_cnt = underrun_cnt_q;
  assign overrun_cnt  = overrun_cnt_q;

endmodule : sample_decimator

// File: tb/tb_sample_decimator.sv
// Directed testbench for sample_decimator (default DECIM_LOG2=4, FIFO_LOG2=2).
module tb_sample_decimator;

  logic               clk;
  logic               rst_n;
  logic               in_en;
  logic signed [15:0] in_sample;
  logic               out_take;
  logic signed [15:0] out_sample;
  logic               out_valid;
  logic [2:0]         level;
  logic               clr_stats;
  logic [7:0]         underrun_cnt;
  logic [7:0]         overrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  sample_decimator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_en        (in_en),
    .in_sample    (in_sample),
    .out_take     (out_take),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .level        (level),
    .clr_stats    (clr_stats),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;       // value on even strobes
    int b;       // value on odd strobes
    int exp_t;   // truncating build
    int exp_r;   // rounding build
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe cycle followed by one idle cycle.
  task automatic strobe(input int v, input logic take);
    in_sample = 16'(v);
    in_en     = 1'b1;
    out_take  = take;
    tick();
    in_en     = 1'b0;
    out_take  = 1'b0;
    tick();
  endtask

  task automatic take1(input logic clr);
    out_take  = 1'b1;
    clr_stats = clr;
    tick();
    out_take  = 1'b0;
    clr_stats = 1'b0;
    tick();
  endtask

  // A full block of identical samples; take_last pulses out_take with the 16th.
  task automatic push16(input int v, input logic take_last);
    for (int k = 0; k < 15; k++) strobe(v, 1'b0);
    strobe(v, take_last);
  endtask

  initial begin
    int exp;
    vecs[0] = '{1000,   1000,   1000,   1000};
    vecs[1] = '{3,      4,      3,      4};
    vecs[2] = '{-32768, -32768, -32768, -32768};
    vecs[3] = '{32767,  32767,  32767,  32767};
    vecs[4] = '{-3,     -4,     -4,     -3};
    vecs[5] = '{0,      1,      0,      1};
    vecs[6] = '{-1,     0,      -1,     0};
    vecs[7] = '{100,    -100,   0,      0};
    vecs[8] = '{32767,  -32768, -1,     0};

    rst_n     = 1'b0;
    in_en     = 1'b0;
    in_sample = '0;
    out_take  = 1'b0;
    clr_stats = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_sample", int'(out_sample), 0);
    chk("rst_underrun", int'(underrun_cnt), 0);
    chk("rst_overrun", int'(overrun_cnt), 0);

    // Averaging vectors: one push per 16 strobes, then a single take.
    for (int i = 0; i < 9; i++) begin
`ifdef DECIM_ROUND_EN
      exp = vecs[i].exp_r;
`else
      exp = vecs[i].exp_t;
`endif
      for (int k = 0; k < 15; k++) strobe((k % 2 == 0) ? vecs[i].a : vecs[i].b, 1'b0);
      chk($sformatf("v%0d_valid_pre", i), int'(out_valid), 0);
      strobe(vecs[i].b, 1'b0);
      chk($sformatf("v%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("v%0d_level", i), int'(level), 1);
      chk($sformatf("v%0d_sample", i), int'(out_sample), exp);
      take1(1'b0);
      chk($sformatf("v%0d_level_post", i), int'(level), 0);
      chk($sformatf("v%0d_hold", i), int'(out_sample), exp);
    end
    chk("vec_underrun", int'(underrun_cnt), 0);

    // Output latency: out_valid high right after the 16th strobe edge.
    for (int k = 0; k < 15; k++) strobe(50, 1'b0);
    in_sample = 16'(50);
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_level", int'(level), 1);
    tick();
    take1(1'b0);

    // Overflow: four fills, a dropped fifth, then push+take while full.
    push16(100, 1'b0);
    push16(200, 1'b0);
    push16(300, 1'b0);
    push16(400, 1'b0);
    chk("full_level", int'(level), 4);
    chk("full_overrun0", int'(overrun_cnt), 0);
    push16(500, 1'b0);
    chk("ovr_level", int'(level), 4);
    chk("ovr_cnt", int'(overrun_cnt), 1);
    chk("ovr_head", int'(out_sample), 100);
    push16(600, 1'b1);
    chk("pp_full_level", int'(level), 4);
    chk("pp_full_overrun", int'(overrun_cnt), 1);
    chk("pp_full_head", int'(out_sample), 200);
    take1(1'b0);
    chk("drain1", int'(out_sample), 300);
    take1(1'b0);
    chk("drain2", int'(out_sample), 400);
    take1(1'b0);
    chk("drain3", int'(out_sample), 600);
    take1(1'b0);
    chk("drain_level", int'(level), 0);
    chk("drain_hold", int'(out_sample), 600);
    chk("drain_underrun", int'(underrun_cnt), 0);

    // Underrun saturation and clear priority.
    for (int k = 0; k < 300; k++) take1(1'b0);
    chk("udr_sat", int'(underrun_cnt), 255);
    chk("udr_hold", int'(out_sample), 600);
    chk("udr_valid", int'(out_valid), 0);
    take1(1'b1);
    chk("clr_underrun", int'(underrun_cnt), 0);
    chk("clr_overrun", int'(overrun_cnt), 0);

    // Push and take together on an empty FIFO.
    push16(777, 1'b1);
    chk("pp_empty_underrun", int'(underrun_cnt), 1);
    chk("pp_empty_level", int'(level), 1);
    chk("pp_empty_head", int'(out_sample), 777);

    // Asynchronous reset mid-block discards the partial sum.
    for (int k = 0; k < 7; k++) strobe(5000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_sample", int'(out_sample), 0);
    chk("arst_underrun", int'(underrun_cnt), 0);
    chk("arst_overrun", int'(overrun_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) strobe(200, 1'b0);
    chk("arst_no_early_push", int'(out_valid), 0);
    strobe(200, 1'b0);
    chk("arst_push_valid", int'(out_valid), 1);
    chk("arst_push_sample", int'(out_sample), 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sample_decimator

// File: doc/sample_decimator.md
SAMPLE_DECIMATOR -- requirements
Module: sample_decimator

Interface
REQ-001 Parameter DECIM_LOG2, default 4, log2 of the input samples averaged per output sample (range 1..6).
REQ-002 Parameter FIFO_LOG2, default 2, log2 of the output FIFO depth (default 4 entries).
REQ-003 clk  in  1  system clock (sys_clk domain, shared with the SID core and filter); single clock.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_en  in  1  sample strobe, one-cycle pulse at the SID 1 MHz enable rate.
REQ-006 in_sample  in  16  signed filtered SID output, valid when in_en=1.
REQ-007 out_take  in  1  one-cycle pop request from the I2S encoder's "sampled" pulse.
REQ-008 out_sample  out  16  signed FIFO head, or the last-popped value while the FIFO is empty.
REQ-009 out_valid  out  1  FIFO not empty.
REQ-010 level  out  FIFO_LOG2+1  current FIFO occupancy.
REQ-011 clr_stats  in  1  synchronous clear of both counters.
REQ-012 underrun_cnt  out  8  saturating count of pops while empty.
REQ-013 overrun_cnt  out  8  saturating count of pushes dropped because the FIFO is full.

Function
REQ-014 Accumulator SHALL be signed, 16+DECIM_LOG2 bits wide, with a phase counter of DECIM_LOG2 bits; both SHALL advance only on in_en.
REQ-015 On the in_en edge where phase = 2^DECIM_LOG2-1, the block SHALL compute result = (accum + in_sample) >>> DECIM_LOG2 (arithmetic shift), push it, reload accum to 0 and wrap phase to 0, all on the same edge.
REQ-016 Push SHALL write the FIFO on that same edge; out_valid and level SHALL reflect the push on the following cycle (latency 1 clk from the final in_en).
REQ-017 A pop (out_take=1 with level>0) SHALL advance the head; out_sample SHALL show the next entry, or hold the popped value if the FIFO becomes empty.
REQ-018 A pop with level=0 SHALL leave out_sample unchanged and increment underrun_cnt, saturating at 255.
REQ-019 A push with level=full and no same-cycle pop SHALL drop the new sample and increment overrun_cnt, saturating at 255; FIFO contents SHALL be unchanged.
REQ-020 Simultaneous push and pop when full SHALL both succeed; level SHALL be unchanged.
REQ-021 Simultaneous push and pop when empty SHALL count an underrun; the pushed sample SHALL be stored (level becomes 1).
REQ-022 in_en and out_take are independent; no back-pressure to upstream; in_en SHALL never stall.
REQ-023 clr_stats SHALL zero both counters on the next edge; clr_stats takes priority over a same-cycle increment.
REQ-024 FIFO read/write pointers SHALL be FIFO_LOG2+1 bits and wrap naturally; full = MSBs differ and the remaining bits are equal.

Reset
REQ-025 On rst_n=0, asynchronously: accum=0, phase=0, pointers=0, level=0, out_valid=0, out_sample=0, and both counters=0.
REQ-026 Reset mid-accumulation SHALL discard the partial sum; the first output after release SHALL be built from a full 2^DECIM_LOG2 fresh inputs.

Configuration
REQ-027 Macro DECIM_ROUND_EN: when defined, the block SHALL add 2^(DECIM_LOG2-1) before the shift and saturate the result to [-32768, 32767]; when undefined, the block SHALL truncate (floor) with no saturation logic.

Structure
REQ-028 Package sid_audio_pkg SHALL hold the sample_t type (signed 16) and the DECIM_LOG2/FIFO_LOG2 defaults, shared with the filter and I2S stages.
REQ-029 The FIFO SHALL be the sub-module sample_fifo (push/pop/level, full/empty); accumulation, rounding and statistics SHALL live in sample_decimator.

Verification
REQ-030 16 in_en pulses with in_sample=1000 -> exactly one push of 1000; out_valid rises 1 clk after the 16th strobe.
REQ-031 Alternating 3 and 4 over 16 strobes -> truncation build gives 3; DECIM_ROUND_EN build gives 4; all -32768 -> -32768 in both builds.
REQ-032 Five pushes with no take (depth 4) -> level=4, overrun_cnt=1, head is the first sample; a push and take in the same cycle while full -> level stays 4, overrun_cnt unchanged.
REQ-033 300 takes on an empty FIFO -> underrun_cnt=255 and out_sample holds the last value; clr_stats asserted together with a take -> counter reads 0.
REQ-034 rst_n pulsed low after 7 strobes -> all outputs 0 immediately; the next push occurs only after 16 further strobes.
